pipeline_run_controller: RTL

Sequencing controller for the 5-stage MIPS core: it owns the core's `i_stall` input and the instruction-memory write port. It accepts host commands over a valid/ready handshake to load a program, run, single-step, halt and clear. It also detects the program's halt word at the fetch stage and drains the pipeline before reporting completion. It sits between the debug/host interface and `mips`, and drives `i_stall` directly.

---
 rtl/mips_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_run_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline run controller.
// Holds the host command encodings, the controller state encoding and the
// default instruction word that marks the end of a program.
package mips_ctrl_pkg;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;
    localparam logic [2:0] CMD_STEP  = 3'd3;
    localparam logic [2:0] CMD_HALT  = 3'd4;
    localparam logic [2:0] CMD_CLEAR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset, clears the count
//   inc   - add one this cycle (ignored once the count is all ones)
//   clr   - synchronous clear, has priority over inc
//   count - registered count value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Sequencing controller for the 5-stage MIPS core. Owns the core stall input
// and the instruction-memory write port; takes host commands over a
// valid/ready handshake (LOAD/RUN/STEP/HALT/CLEAR), detects the halt word at
// fetch and drains the pipeline before reporting completion.
// Ports:
//   clk, rst (sync, active-low)
//   i_cmd_valid/o_cmd_ready/i_cmd/i_cmd_data - host command handshake
//   i_fetch_instr  - instruction currently output by IF
//   o_stall        - core stall
//   o_pipe_rst     - active-low core reset pulse issued by CLEAR
//   o_imem_we/o_imem_addr/o_imem_wdata - program load port
//   o_state, o_cycle_count, o_halted, o_err - status
module pipeline_run_controller
    import mips_ctrl_pkg::*;
#(
    parameter int                 SIZE         = 32,
    parameter int                 IMEM_ADDR_W  = 10,
    parameter int                 CYCLE_W      = 32,
    parameter int                 DRAIN_CYCLES = 4,
    parameter logic [SIZE-1:0]    HALT_WORD    = DEFAULT_HALT_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [2:0]             i_cmd,
    input  logic [SIZE-1:0]        i_cmd_data,
    input  logic [SIZE-1:0]        i_fetch_instr,
    output logic                   o_stall,
    output logic                   o_pipe_rst,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [SIZE-1:0]        o_imem_wdata,
    output logic [2:0]             o_state,
    output logic [CYCLE_W-1:0]     o_cycle_count,
    output logic                   o_halted,
    output logic                   o_err
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     stall_q, stall_d;
    logic                     pipe_rst_q, pipe_rst_d;
    logic                     ready_q, ready_d;
    logic                     we_q, we_d;
    logic [IMEM_ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE-1:0]          wdata_q, wdata_d;
    logic [IMEM_ADDR_W-1:0]   ptr_q, ptr_d;
    logic                     full_q, full_d;
    logic                     halted_q, halted_d;
    logic                     err_q, err_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;

    logic accept;
    logic halt_fetch;
    logic clear;
    logic cnt_inc;

    assign accept     = i_cmd_valid & ready_q;
    assign halt_fetch = (i_fetch_instr == HALT_WORD);
    assign cnt_inc    = ~stall_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        full_d     = full_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        drain_d    = drain_q;
        pipe_rst_d = 1'b1;
        clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP, CMD_HALT: ;
                        CMD_LOAD: begin
                            if (full_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_LOAD;
                                we_d    = 1'b1;
                                addr_d  = ptr_q;
                                wdata_d = i_cmd_data;
                                ptr_d   = ptr_q + 1'b1;
                                // Last slot written: pointer wraps, flag blocks further loads.
                                if (ptr_q == '1) begin
                                    full_d = 1'b1;
                                end
                            end
                        end
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: clear = 1'b1;
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_RUN: begin
                // Halt word and HALT command in the same cycle share one drain entry.
                if (halt_fetch || (accept && (i_cmd == CMD_HALT))) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
                if (accept && (i_cmd != CMD_HALT) && (i_cmd != CMD_NOP)) begin
                    err_d = 1'b1;
                end
            end
            ST_STEP: state_d = halt_fetch ? ST_DONE : ST_IDLE;
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    if (i_cmd == CMD_CLEAR) begin
                        clear   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (i_cmd != CMD_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            pipe_rst_d = 1'b0;
            ptr_d      = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
        end

        halted_d = (state_d == ST_DONE);
        stall_d  = !((state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN));
        // Hold off the host while the core sits in its reset pulse.
        ready_d  = ((state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE)) && !clear;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stall_q    <= 1'b1;
            pipe_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ptr_q      <= '0;
            full_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            pipe_rst_q <= pipe_rst_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ptr_q      <= ptr_d;
            full_q     <= full_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
        end
    end

    sat_counter #(
        .WIDTH(CYCLE_W)
    ) u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clr   (clear),
        .count (o_cycle_count)
    );

    assign o_cmd_ready  = ready_q;
    assign o_stall      = stall_q;
    assign o_pipe_rst   = pipe_rst_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_state      = state_q;
    assign o_halted     = halted_q;
    assign o_err        = err_q;

endmodule
